// File: rtl/bresenham_line_drawer.sv
// Bresenham line engine feeding vga_adapter (160x120 mode).
// Accepts two endpoints and a colour, then emits one pixel per clock on
// x/y/colour/plot for lines in any of the eight octants. Output strobes are
// registered one cycle behind the walking state, which gives the fixed
// two-cycle start-to-first-plot latency seen by the adapter.
module bresenham_line_drawer #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int CW = 3
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y0,
  input  logic [YW-1:0] y1,
  input  logic [CW-1:0] colour_in,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [CW-1:0] colour,
  output logic          plot,
  output logic          busy,
  output logic          done
);

  // Signed widths sized so that no endpoint pair can overflow the error term.
  localparam int DW  = XW + 2;
  localparam int EW  = XW + 3;
  localparam int E2W = XW + 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, next_state;

  // Latched request; input changes after acceptance have no effect.
  logic [XW-1:0] x0_r, x1_r;
  logic [YW-1:0] y0_r, y1_r;

  // Walk state.
  logic signed [DW-1:0] dx, dy;
  logic signed [EW-1:0] err;
  logic                 sx_pos, sy_pos;
  logic [XW-1:0]        cur_x;
  logic [YW-1:0]        cur_y;

  // Combinational setup and step terms.
  logic signed [DW-1:0]  x0_s, x1_s, y0_s, y1_s;
  logic signed [DW-1:0]  dx_init, dy_init;
  logic signed [EW-1:0]  err_init, err_next;
  logic signed [E2W-1:0] e2;
  logic                  step_x, step_y, at_end;
  logic [XW-1:0]         cur_x_next;
  logic [YW-1:0]         cur_y_next;

  // Setup (dx, dy, err) and per-pixel step arithmetic.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned, which would otherwise infer a latch.
    x0_s       = signed'({2'b00, x0_r});
    x1_s       = signed'({2'b00, x1_r});
    y0_s       = signed'({{(DW-YW){1'b0}}, y0_r});
    y1_s       = signed'({{(DW-YW){1'b0}}, y1_r});
    dx_init    = (x0_r < x1_r) ? (x1_s - x0_s) : (x0_s - x1_s);
    dy_init    = (y0_r < y1_r) ? (y0_s - y1_s) : (y1_s - y0_s);
    err_init   = EW'(dx_init) + EW'(dy_init);

    at_end     = (cur_x == x1_r) && (cur_y == y1_r);
    e2         = E2W'(err) <<< 1;
    step_x     = (e2 >= E2W'(dy));
    step_y     = (e2 <= E2W'(dx));

    err_next   = err;
    cur_x_next = cur_x;
    cur_y_next = cur_y;
    if (step_x) begin
      err_next   = err_next + EW'(dy);
      cur_x_next = sx_pos ? (cur_x + XW'(1)) : (cur_x - XW'(1));
    end
    if (step_y) begin
      err_next   = err_next + EW'(dx);
      cur_y_next = sy_pos ? (cur_y + YW'(1)) : (cur_y - YW'(1));
    end
  end

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = INIT;
      INIT:    next_state = DRAW;
      DRAW:    if (at_end) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Capture endpoints and colour when a request is accepted in IDLE.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x0_r   <= '0;
      x1_r   <= '0;
      y0_r   <= '0;
      y1_r   <= '0;
      colour <= '0;
    end else if (state == IDLE && start) begin
      x0_r   <= x0;
      x1_r   <= x1;
      y0_r   <= y0;
      y1_r   <= y1;
      colour <= colour_in;
    end
  end

  // Load the walk in INIT, then advance one pixel per DRAW cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dx     <= '0;
      dy     <= '0;
      err    <= '0;
      sx_pos <= 1'b0;
      sy_pos <= 1'b0;
      cur_x  <= '0;
      cur_y  <= '0;
    end else if (state == INIT) begin
      dx     <= dx_init;
      dy     <= dy_init;
      err    <= err_init;
      sx_pos <= (x0_r < x1_r);
      sy_pos <= (y0_r < y1_r);
      cur_x  <= x0_r;
      cur_y  <= y0_r;
    end else if (state == DRAW && !at_end) begin
      err    <= err_next;
      cur_x  <= cur_x_next;
      cur_y  <= cur_y_next;
    end
  end

  // Registered adapter-facing outputs, one cycle behind the walk state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x    <= '0;
      y    <= '0;
      plot <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      plot <= (state == DRAW);
      busy <= (state == INIT) || (state == DRAW);
      done <= (state == DONE);
      if (state == DRAW) begin
        x <= cur_x;
        y <= cur_y;
      end
    end
  end

endmodule

// File: tb/tb_bresenham_line_drawer.sv
// Directed bench for bresenham_line_drawer: expected pixels are queued when a
// line is requested and popped as the DUT plots them.
module tb_bresenham_line_drawer;

  typedef struct packed {
    logic [7:0] px;
    logic [6:0] py;
  } pix_t;

  logic       clock;
  logic       resetn;
  logic       start;
  logic [7:0] x0_i, x1_i;
  logic [6:0] y0_i, y1_i;
  logic [2:0] colour_i;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;

  int   checks   = 0;
  int   failures = 0;
  pix_t sb[$];

  bresenham_line_drawer #(.XW(8), .YW(7), .CW(3)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .x0        (x0_i),
    .x1        (x1_i),
    .y0        (y0_i),
    .y1        (y1_i),
    .colour_in (colour_i),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .busy      (busy),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic push_pixel(input int px, input int py);
    pix_t p;
    p.px = px[7:0];
    p.py = py[6:0];
    sb.push_back(p);
  endtask

  // Textbook integer Bresenham, all octants.
  task automatic model_push(input int ax0, input int ay0, input int ax1, input int ay1);
    int ddx, ddy, sx, sy, er, e2, cx, cy;
    ddx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    ddy = (ay1 > ay0) ? ay0 - ay1 : ay1 - ay0;
    sx  = (ax0 < ax1) ? 1 : -1;
    sy  = (ay0 < ay1) ? 1 : -1;
    er  = ddx + ddy;
    cx  = ax0;
    cy  = ay0;
    for (int i = 0; i < 400; i++) begin
      push_pixel(cx, cy);
      if (cx == ax1 && cy == ay1) break;
      e2 = 2 * er;
      if (e2 >= ddy) begin er += ddy; cx += sx; end
      if (e2 <= ddx) begin er += ddx; cy += sy; end
    end
  endtask

  // Request a line and follow it to done, checking pixels, colour and timing.
  // inject_edge > 0 pulses start with a different line during the walk.
  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                          input logic [2:0] acol, input int inject_edge, input string name);
    int   n_exp, first_plot, done_edge, plots;
    pix_t p;
    n_exp      = sb.size();
    first_plot = -1;
    done_edge  = -1;
    plots      = 0;
    @(negedge clock);
    x0_i     = ax0[7:0];
    y0_i     = ay0[6:0];
    x1_i     = ax1[7:0];
    y1_i     = ay1[6:0];
    colour_i = acol;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int e = 1; e <= n_exp + 10; e++) begin
      if (e == inject_edge) begin
        x0_i     = 8'd50;
        y0_i     = 7'd50;
        x1_i     = 8'd60;
        y1_i     = 7'd61;
        colour_i = ~acol;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      if (e == 1) begin
        check({name, ":busy_init"}, 32'(busy), 1);
        check({name, ":plot_init"}, 32'(plot), 0);
      end
      if (plot) begin
        plots++;
        if (first_plot < 0) first_plot = e;
        if (sb.size() == 0) begin
          check({name, ":extra_plot"}, plots, n_exp);
        end else begin
          p = sb.pop_front();
          check({name, ":x"}, 32'(x), 32'(p.px));
          check({name, ":y"}, 32'(y), 32'(p.py));
          check({name, ":colour"}, 32'(colour), 32'(acol));
          check({name, ":busy_draw"}, 32'(busy), 1);
        end
      end
      if (done) begin
        done_edge = e;
        check({name, ":busy_done"}, 32'(busy), 0);
        check({name, ":plot_done"}, 32'(plot), 0);
        break;
      end
    end
    start = 1'b0;
    check({name, ":first_plot_edge"}, first_plot, 2);
    check({name, ":done_edge"}, done_edge, n_exp + 2);
    check({name, ":plot_count"}, plots, n_exp);
    check({name, ":sb_left"}, sb.size(), 0);
    sb.delete();
    @(negedge clock);
    check({name, ":done_pulse_end"}, 32'(done), 0);
    check({name, ":colour_hold"}, 32'(colour), 32'(acol));
  endtask

  initial begin
    int plots_after;
    resetn   = 1'b0;
    start    = 1'b0;
    x0_i     = '0;
    y0_i     = '0;
    x1_i     = '0;
    y1_i     = '0;
    colour_i = '0;

    // Reset values.
    #12;
    check("rst:plot", 32'(plot), 0);
    check("rst:busy", 32'(busy), 0);
    check("rst:done", 32'(done), 0);
    check("rst:x", 32'(x), 0);
    check("rst:y", 32'(y), 0);
    check("rst:colour", 32'(colour), 0);
    @(negedge clock);
    resetn = 1'b1;

    // Reset during the third pixel of (0,0)->(20,0).
    @(negedge clock);
    x0_i = 8'd0; y0_i = 7'd0; x1_i = 8'd20; y1_i = 7'd0; colour_i = 3'b010;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    check("midrst:plot_before", 32'(plot), 1);
    check("midrst:x_before", 32'(x), 2);
    #2 resetn = 1'b0;
    #1;
    check("midrst:plot", 32'(plot), 0);
    check("midrst:busy", 32'(busy), 0);
    check("midrst:done", 32'(done), 0);
    @(negedge clock);
    resetn = 1'b1;
    plots_after = 0;
    repeat (25) begin
      @(negedge clock);
      if (plot || busy || done) plots_after++;
    end
    check("midrst:quiet_after", plots_after, 0);

    // Single point.
    push_pixel(10, 10);
    run_line(10, 10, 10, 10, 3'b111, 0, "point");

    // Horizontal.
    for (int i = 0; i <= 4; i++) push_pixel(i, 0);
    run_line(0, 0, 4, 0, 3'b001, 0, "horiz");

    // Shallow.
    push_pixel(0, 0); push_pixel(1, 1); push_pixel(2, 1); push_pixel(3, 2); push_pixel(4, 2);
    run_line(0, 0, 4, 2, 3'b011, 0, "shallow");

    // Reverse diagonal.
    push_pixel(10, 10); push_pixel(11, 9); push_pixel(12, 8); push_pixel(13, 7);
    run_line(10, 10, 13, 7, 3'b100, 0, "revdiag");

    // Full-screen diagonal back to the origin.
    model_push(159, 119, 0, 0);
    check("long:model_count", sb.size(), 160);
    check("long:model_last", 32'(sb[$]), 0);
    run_line(159, 119, 0, 0, 3'b110, 0, "long");

    // Start while busy must be ignored.
    model_push(0, 0, 9, 3);
    run_line(0, 0, 9, 3, 3'b101, 4, "busy_start");

    // Steep and left-going octants.
    model_push(5, 20, 2, 3);
    run_line(5, 20, 2, 3, 3'b010, 0, "steep_up_left");
    model_push(100, 5, 90, 40);
    run_line(100, 5, 90, 40, 3'b001, 0, "steep_down_left");
    model_push(30, 60, 3, 50);
    run_line(30, 60, 3, 50, 3'b111, 0, "shallow_up_left");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bresenham_line_drawer.md
# bresenham_line_drawer

Pixel-generating stage that sits directly upstream of `vga_adapter`. It accepts two endpoints and a colour, then walks the Bresenham line between them and emits one pixel per clock on `x`/`y`/`colour`/`plot`. These outputs wire straight to the adapter's ports of the same names in 160x120 mode. It replaces the fixed-coordinate, key-driven plot with a hardware line engine for all eight octants.

## Interface
- `XW`, 8: width of x coordinates; matches adapter `x` in 160x120 mode.
- `YW`, 7: width of y coordinates; matches adapter `y`.
- `CW`, 3: colour width; matches adapter `colour` (MONOCHROME = "FALSE").
- `clock`  in  1  single clock; all state changes on the rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request to draw; sampled only in IDLE.
- `x0`, `x1`  in  XW  endpoint x coordinates, unsigned.
- `y0`, `y1`  in  YW  endpoint y coordinates, unsigned.
- `colour_in`  in  CW  line colour.
- `x`  out  XW  current pixel x; to adapter `x`.
- `y`  out  YW  current pixel y; to adapter `y`.
- `colour`  out  CW  latched line colour; to adapter `colour`.
- `plot`  out  1  write strobe; to adapter `plot`.
- `busy`  out  1  high from the cycle after `start` is accepted through the last plot cycle.
- `done`  out  1  one-cycle pulse after the last pixel.

## Operation
- States: IDLE, INIT, DRAW, DONE.
- **IDLE**
  - `start`=1 latches `x0`, `y0`, `x1`, `y1` and `colour_in` into internal registers, then moves to INIT.
  - While `busy`=1, `start` is ignored. Input changes after acceptance are ignored.
- **INIT** (1 cycle) computes:
  - dx = |x1−x0| and dy = −|y1−y0|.
  - sx = +1 if x0<x1, else −1. sy = +1 if y0<y1, else −1.
  - err = dx+dy.
  - Loads cur_x = x0 and cur_y = y0. Moves to DRAW.
- **DRAW** (one pixel per cycle)
  - `plot`=1, `x`=cur_x, `y`=cur_y.
  - If cur_x==x1 and cur_y==y1, go to DONE. Otherwise compute e2 = 2·err, then:
    - If e2 ≥ dy: err += dy and cur_x += sx.
    - If e2 ≤ dx: err += dx and cur_y += sy.
    - Both updates apply in the same cycle, and the err result is their sum.
- **DONE** (1 cycle): `done`=1, then return to IDLE.
- Arithmetic widths:
  - dx and dy are signed at XW+2 bits.
  - err is signed at XW+3 bits.
  - e2 is signed at XW+4 bits.
  - No overflow is possible for any XW-bit endpoints.
  - cur_x and cur_y never step past the endpoint.
- Pixel count is max(|x1−x0|, |y1−y0|) + 1.
- Endpoints equal: exactly one plot.
- No clipping: coordinates ≥160 or ≥120 are emitted unchanged. Range checking belongs to the caller.
- `colour` holds its latched value until the next accepted `start`.

## Timing
- Reset values: `plot`=0, `busy`=0, `done`=0, `x`=0, `y`=0, `colour`=0, state=IDLE.
- Reset takes effect immediately (asynchronously). A reset mid-line aborts the draw with no further plots. After `resetn` rises, the block waits for a new `start`.
- Cycle timeline, with `start` sampled high at edge 0:
  - Edge 1: `busy`=1, state INIT, `plot`=0.
  - Edges 2 .. N+1: `plot`=1, with pixel k on cycle k+2.
  - Edge N+2: `done`=1, `busy`=0, `plot`=0.
  - Edge N+3: IDLE; a new `start` may be accepted on this edge.
- Start-to-first-plot latency is 2 cycles. Throughput is 1 pixel/cycle. Per-line overhead is 3 cycles.
- `x`, `y` and `plot` are registered outputs. The adapter samples them on the same `clock`.

## Test plan
- Single point: (10,10)→(10,10), colour 3'b111 → one plot at (10,10), `done` on the following cycle, 4 cycles total from start.
- Horizontal: (0,0)→(4,0) → plots (0,0),(1,0),(2,0),(3,0),(4,0) on 5 consecutive cycles; first plot 2 cycles after `start`.
- Shallow: (0,0)→(4,2) → plots (0,0),(1,1),(2,1),(3,2),(4,2).
- Reverse diagonal: (10,10)→(13,7) → plots (10,10),(11,9),(12,8),(13,7). Also (159,119)→(0,0) → 160 plots ending at (0,0), none out of range.
- Start while busy: pulse `start` with a different line during DRAW → ignored; original pixel sequence and `colour` are unchanged.
- Reset mid-line: assert `resetn`=0 during the third pixel of (0,0)→(20,0) → `plot`, `busy` and `done` go low immediately. After release, no plot occurs until a new `start`.
